// File: rtl/mem_bist_ram.sv
// Parametrised single-port RAM with a built-in write/readback self-test controller.
// Optional macro MEM_BIST_INV_EN adds inverted-pattern WRITE_INV/READ_INV phases to mode 0 runs.
module mem_bist_ram #(
   parameter int DW    = 16,
   parameter int AW    = 15,
   parameter int DEPTH = 32768
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] a,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] spo,
   input  logic          bist_start,
   input  logic          bist_mode,
   output logic          bist_busy,
   output logic          bist_done,
   output logic          bist_fail,
   output logic [AW-1:0] bist_fail_addr,
   output logic [2:0]    bist_state
);

   // Handshake: bist_start is a one-cycle request, accepted only in IDLE or DONE (bist_busy=0);
   // bist_done is the completion flag and stays high until the next accepted start.

`ifdef MEM_BIST_INV_EN
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WRITE     = 3'd1,
      READ      = 3'd2,
      DONE      = 3'd3,
      WRITE_INV = 3'd4,
      READ_INV  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DONE  = 3'd3
   } state_t;
`endif

   state_t        state, state_nxt;
   logic [AW-1:0] addr;
   logic          addr_clr, addr_inc;
   logic          bist_we, bist_rd, inv;
   logic          start_ok, last, host_in_range, host_we, mismatch;
   logic [DW-1:0] pat, exp_word, rd_word;
   logic [DW-1:0] mem [DEPTH];

`ifdef MEM_BIST_INV_EN
   logic mode_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mode_q <= 1'b0;
      else if (start_ok)
         mode_q <= bist_mode;
   end
`endif

   // Expected word is the address taken modulo 2**DW.
   if (DW <= AW) begin : g_trunc
      assign pat = addr[DW-1:0];
   end else begin : g_ext
      assign pat = {{(DW-AW){1'b0}}, addr};
   end

   assign start_ok      = bist_start && ((state == IDLE) || (state == DONE));
   assign last          = (32'(addr) == 32'(DEPTH - 1));
   assign host_in_range = (32'(a) < 32'(DEPTH));
   assign bist_busy     = (state != IDLE) && (state != DONE);
   assign bist_done     = (state == DONE);
   assign bist_state    = state;
   assign exp_word      = inv ? ~pat : pat;
   assign rd_word       = mem[addr];
   assign mismatch      = bist_rd && (rd_word != exp_word);
   assign host_we       = we && !bist_busy && !start_ok && host_in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr_clr  = 1'b0;
      addr_inc  = 1'b0;
      bist_we   = 1'b0;
      bist_rd   = 1'b0;
      inv       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (bist_start) begin
               state_nxt = bist_mode ? READ : WRITE;
               addr_clr  = 1'b1;
            end
         end
         WRITE: begin
            bist_we = 1'b1;
            if (last) begin
               state_nxt = READ;
               addr_clr  = 1'b1;
            end else begin
               addr_inc = 1'b1;
            end
         end
         READ: begin
            bist_rd = 1'b1;
            if (last) begin
`ifdef MEM_BIST_INV_EN
               state_nxt = mode_q ? DONE : WRITE_INV;
`else
               state_nxt = DONE;
`endif
               addr_clr  = 1'b1;
            end else begin
               addr_inc = 1'b1;
            end
         end
`ifdef MEM_BIST_INV_EN
         WRITE_INV: begin
            bist_we = 1'b1;
            inv     = 1'b1;
            if (last) begin
               state_nxt = READ_INV;
               addr_clr  = 1'b1;
            end else begin
               addr_inc = 1'b1;
            end
         end
         READ_INV: begin
            bist_rd = 1'b1;
            inv     = 1'b1;
            if (last) begin
               state_nxt = DONE;
               addr_clr  = 1'b1;
            end else begin
               addr_inc = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         addr <= '0;
      else if (addr_clr)
         addr <= '0;
      else if (addr_inc)
         addr <= addr + 1'b1;
   end

   // Only the first mismatch of a run is captured; the run itself never stops early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
      end else if (start_ok) begin
         bist_fail      <= 1'b0;
         bist_fail_addr <= '0;
      end else if (mismatch && !bist_fail) begin
         bist_fail      <= 1'b1;
         bist_fail_addr <= addr;
      end
   end

   always_ff @(posedge clk) begin
      if (bist_we)
         mem[addr] <= exp_word;
      else if (host_we)
         mem[a] <= d;
   end

   always_comb begin
      spo = '0;
      if (bist_busy)
         spo = rd_word;
      else if (host_in_range)
         spo = mem[a];
   end

endmodule

// File: doc/mem_bist_ram.md
Name: mem_bist_ram

Overview:
Parametrised single-port RAM, successor to the fixed 32K x 16 memory. It adds a built-in self-test (BIST) controller that performs the address-pattern write/readback check in hardware. Sits wherever a mem32k-class store is used. Gives a pass/fail result and the first failing address without a bench loop.

Parameters:
DW, 16, data width in bits (1..32)
AW, 15, address width in bits
DEPTH, 32768, number of implemented words; must be <= 2**AW

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset of controller state only
we  in  1  host write enable
a  in  AW  host address
d  in  DW  host write data
spo  out  DW  asynchronous read data for the currently selected address
bist_start  in  1  one-cycle pulse that starts a BIST run
bist_mode  in  1  0 = write then read; 1 = read-only check of existing contents
bist_busy  out  1  BIST run in progress
bist_done  out  1  run complete; held until next accepted start
bist_fail  out  1  sticky mismatch flag for the last run
bist_fail_addr  out  AW  address of the first mismatch in the last run

Behaviour:
- Reset values: bist_busy=0, bist_done=0, bist_fail=0, bist_fail_addr=0, FSM=IDLE, internal address=0. Memory array is not reset; spo follows the array.
- Host mode (bist_busy=0):
  - Write: mem[a] <= d on the rising edge when we=1 and a<DEPTH.
  - Read: spo = mem[a] combinationally. Zero read latency.
  - Out-of-range access (a>=DEPTH): write ignored, spo=0.
- Expected pattern: exp(x) = x zero-extended or truncated to DW bits, i.e. x mod 2**DW.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE or DONE: bist_start=1 is sampled at an edge. Next cycle: bist_busy=1, bist_done=0, bist_fail=0, bist_fail_addr=0, internal address=0.
    - bist_mode=0 -> WRITE.
    - bist_mode=1 -> READ.
  - WRITE: one word per cycle, mem[addr] <= exp(addr), addr increments. After addr=DEPTH-1: go to READ, addr=0.
  - READ: one word per cycle. spo = mem[addr], compared with exp(addr) in the same cycle.
    - On mismatch while bist_fail=0: set bist_fail and capture bist_fail_addr=addr.
    - Later mismatches do not update bist_fail_addr.
    - Run always continues to DEPTH-1, then goes to DONE.
  - DONE: bist_busy=0, bist_done=1. Flags are held.
- Cycle counts (without the optional feature): busy for 2*DEPTH cycles in mode 0, DEPTH cycles in mode 1.
- While bist_busy=1:
  - Host we, a and d are ignored.
  - spo shows mem[internal addr]; host must not use it.
  - bist_start is ignored.
- bist_mode is sampled only with an accepted start.
- Address counter never wraps past DEPTH-1. Transitions occur on the terminal count.
- rst asserted mid-run: FSM goes to IDLE immediately and all flags clear. Array contents are partially written and undefined for test purposes.
- bist_start and we in the same cycle from IDLE: start wins; the host write is discarded.

Optional Feature:
MEM_BIST_INV_EN
- Defined:
  - In mode 0, after READ completes, two further phases run: WRITE_INV writes ~exp(addr) to every word, then READ_INV checks ~exp(addr).
  - Busy time becomes 4*DEPTH cycles.
  - Mode 1 remains a single non-inverted READ.
  - bist_fail_addr records the first mismatch across all phases.
- Undefined: only the four base states exist, with behaviour as above.

Test Plan:
1. Host write/read: write a=0x0005 d=0xBEEF, then a=0x7FFF d=0x1234. Read back -> spo=0xBEEF and 0x1234 combinationally. Read a=0x0004 before any write -> no X after BIST pre-fill.
2. Full BIST, mode 0, DEPTH=32768: pulse bist_start -> bist_busy high for exactly 65536 cycles (131072 with MEM_BIST_INV_EN), then bist_done=1, bist_fail=0. Host reads of a=0x1234 then give spo=0x1234 (0xEDCB with INV).
3. Fault detection, mode 1: after a pass, host writes a=0x0100 d=0x0000 and a=0x0200 d=0xFFFF. Start with bist_mode=1 -> bist_fail=1, bist_fail_addr=0x0100, busy for 32768 cycles.
4. Width truncation: DW=8, AW=10, DEPTH=1000, mode 0 -> pass. Then a=0x3E7 reads spo=0xE7. Host write to a=0x3E8 is ignored and spo=0 there.
5. Reset mid-run: assert rst at cycle 100 of WRITE -> outputs return to reset values in the same cycle. A following start with mode 0 -> pass.
6. Start during busy and start/we collision: second bist_start at cycle 10 -> run length unchanged. bist_start with we=1, a=0x0000, d=0xAAAA -> run starts and the write is dropped (final mem[0]=0x0000).
